// File: rtl/adc_spi_multi_pkg.sv
// Types and helpers shared by the adc_spi_multi capture path.
`include "adc_defs.vh"

package adc_spi_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = `ADC_ST_IDLE,
        ST_CONV  = `ADC_ST_CONV,
        ST_QUIET = `ADC_ST_QUIET
    } adc_state_e;

    // Width of a counter running 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_spi_multi_if.sv
// ADC serial lines plus the parallel sample bus towards the filter bank.
interface adc_spi_multi_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 12,
    parameter int LEAD_W = 4
);
    logic                     cs_o;
    logic                     sclk_o;
    logic [N_CH-1:0]          data_i;
    logic [N_CH*DATA_W-1:0]   data_o;
    logic [N_CH*LEAD_W-1:0]   lead_o;
    logic                     valid_o;
    logic                     err_o;

    modport master (
        output cs_o, sclk_o, data_o, lead_o, valid_o, err_o,
        input  data_i
    );

    modport slave (
        input  cs_o, sclk_o, data_o, lead_o, valid_o, err_o,
        output data_i
    );
endinterface

// File: rtl/adc_defs.vh
// Shared state encodings and derived widths for the multi-channel ADC capture path.
`ifndef ADC_DEFS_VH
`define ADC_DEFS_VH

`define ADC_ST_IDLE  2'd0
`define ADC_ST_CONV  2'd1
`define ADC_ST_QUIET 2'd2

// Expands in any scope that has FRAME_BITS and DATA_W parameters.
`define ADC_LEAD_W (FRAME_BITS - DATA_W)

`endif

// File: rtl/adc_shift_ch.sv
// One channel's MSB-first frame shift register; frame_o shows the value after the
// current shift so the final bit can be loaded out on its capture edge.
module adc_shift_ch #(
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  shift_i,
    input  logic                  din_i,
    output logic [FRAME_BITS-1:0] frame_o
);
    logic [FRAME_BITS-1:0] sh_q;
    logic [FRAME_BITS-1:0] sh_d;

    assign sh_d    = shift_i ? {sh_q[FRAME_BITS-2:0], din_i} : sh_q;
    assign frame_o = sh_d;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end
endmodule

// File: rtl/adc_spi_multi.sv
// N_CH lock-stepped serial ADC capture: fixed-rate CS/SCLK framing, parallel sample out
// with a one-cycle valid strobe, no backpressure. ADC_SIGNED_EN selects two's-complement output.
`include "adc_defs.vh"

module adc_spi_multi
    import adc_spi_multi_pkg::*;
#(
    parameter int SCLK_DIV   = 4,
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int N_CH       = 2,
    parameter int SAMPLE_DIV = 2268,
    parameter int QUIET_CYC  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    adc_spi_multi_if.master  bus,
    output logic             ovr_o,
    output logic             busy_o
);
    localparam int LEAD_W = `ADC_LEAD_W;
    localparam int SMP_W  = cnt_w(SAMPLE_DIV);
    localparam int DIV_W  = cnt_w(SCLK_DIV);
    localparam int RISE_W = cnt_w(FRAME_BITS);
    localparam int QUI_W  = cnt_w(QUIET_CYC);

    localparam logic [SMP_W-1:0]  SMP_MAX  = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCLK_DIV - 1);
    localparam logic [RISE_W-1:0] RISE_MAX = RISE_W'(FRAME_BITS - 1);
    localparam logic [QUI_W-1:0]  QUI_MAX  = QUI_W'(QUIET_CYC - 1);

`ifdef ADC_SIGNED_EN
    // Offset binary to two's complement is a flip of the sample MSB.
    localparam logic [DATA_W-1:0] SIGN_MASK = DATA_W'(1) << (DATA_W - 1);
`else
    localparam logic [DATA_W-1:0] SIGN_MASK = '0;
`endif

    adc_state_e state_q, state_d;
    logic [SMP_W-1:0]         smp_q, smp_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [RISE_W-1:0]        rise_q, rise_d;
    logic [QUI_W-1:0]         quiet_q, quiet_d;
    logic                     cs_q, cs_d;
    logic                     sclk_q, sclk_d;
    logic [N_CH*DATA_W-1:0]   data_q, data_d;
    logic [N_CH*LEAD_W-1:0]   lead_q, lead_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic                     ovr_q, ovr_d;

    logic                     tick;
    logic                     start;
    logic                     shift_en;
    logic                     shift_clr;
    logic [N_CH*DATA_W-1:0]   samp_all;
    logic [N_CH*LEAD_W-1:0]   lead_all;
    logic [N_CH-1:0]          lead_nz;

    // A reset or a new frame discards whatever partial frame is in the shifters.
    assign shift_clr = rst_i | start;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [FRAME_BITS-1:0] frame_nxt;

        adc_shift_ch #(
            .FRAME_BITS (FRAME_BITS)
        ) u_shift (
            .clk_i   (clk_i),
            .clr_i   (shift_clr),
            .shift_i (shift_en),
            .din_i   (bus.data_i[c]),
            .frame_o (frame_nxt)
        );

        assign samp_all[c*DATA_W +: DATA_W] = frame_nxt[DATA_W-1:0] ^ SIGN_MASK;
        assign lead_all[c*LEAD_W +: LEAD_W] = frame_nxt[FRAME_BITS-1:DATA_W];
        assign lead_nz[c]                   = |frame_nxt[FRAME_BITS-1:DATA_W];
    end

    always_comb begin
        state_d  = state_q;
        smp_d    = smp_q;
        div_d    = div_q;
        rise_d   = rise_q;
        quiet_d  = quiet_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        data_d   = data_q;
        lead_d   = lead_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        ovr_d    = ovr_q;
        start    = 1'b0;
        shift_en = 1'b0;

        tick = en_i && (smp_q == SMP_MAX);
        if (!en_i || tick) begin
            smp_d = '0;
        end else begin
            smp_d = smp_q + SMP_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_CONV;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    rise_d  = '0;
                    start   = 1'b1;
                end
            end
            ST_CONV: begin
                if (tick) begin
                    ovr_d = 1'b1;
                end
                if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Capture on the edge that drives SCLK high; the last one closes the frame.
                    if (!sclk_q) begin
                        shift_en = 1'b1;
                        if (rise_q == RISE_MAX) begin
                            state_d = ST_QUIET;
                            cs_d    = 1'b1;
                            rise_d  = '0;
                            quiet_d = '0;
                            valid_d = 1'b1;
                            data_d  = samp_all;
                            lead_d  = lead_all;
                            err_d   = |lead_nz;
                        end else begin
                            rise_d = rise_q + RISE_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_QUIET: begin
                if (tick) begin
                    ovr_d = 1'b1;
                end
                if (quiet_q == QUI_MAX) begin
                    state_d = ST_IDLE;
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + QUI_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            smp_q   <= '0;
            div_q   <= '0;
            rise_q  <= '0;
            quiet_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            data_q  <= '0;
            lead_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            div_q   <= div_d;
            rise_q  <= rise_d;
            quiet_q <= quiet_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            lead_q  <= lead_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.cs_o    = cs_q;
    assign bus.sclk_o  = sclk_q;
    assign bus.data_o  = data_q;
    assign bus.lead_o  = lead_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;
    assign ovr_o       = ovr_q;
    assign busy_o      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_adc_spi_multi.sv
// Directed/randomised bench for adc_spi_multi: a default-rate instance and a fast-tick instance.
module tb_adc_spi_multi;

`ifdef ADC_SIGNED_EN
    localparam logic [11:0] SMASK = 12'h800;
`else
    localparam logic [11:0] SMASK = 12'h000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst0, rst1, en0, en1;
    logic ovr0, ovr1, busy0, busy1;

    adc_spi_multi_if #(.N_CH(2), .DATA_W(12), .LEAD_W(4)) if0 ();
    adc_spi_multi_if #(.N_CH(2), .DATA_W(12), .LEAD_W(4)) if1 ();

    adc_spi_multi dut0 (
        .clk_i  (clk),
        .rst_i  (rst0),
        .en_i   (en0),
        .bus    (if0),
        .ovr_o  (ovr0),
        .busy_o (busy0)
    );

    adc_spi_multi #(.SAMPLE_DIV(100), .SCLK_DIV(4)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst1),
        .en_i   (en1),
        .bus    (if1),
        .ovr_o  (ovr1),
        .busy_o (busy1)
    );

    // ADC models: latch the word when CS falls, present the next bit MSB-first on each SCLK fall.
    logic [15:0] word0 [2];
    logic [15:0] word1 [2];
    logic [15:0] lat0  [2];
    logic [15:0] lat1  [2];
    logic [15:0] sh0   [2];
    logic [15:0] sh1   [2];

    always @(negedge if0.cs_o) begin
        for (int c = 0; c < 2; c++) begin
            lat0[c] = word0[c];
            sh0[c]  = word0[c];
        end
    end
    always @(negedge if0.sclk_o) begin
        if (!if0.cs_o) begin
            for (int c = 0; c < 2; c++) begin
                if0.data_i[c] = sh0[c][15];
                sh0[c] = {sh0[c][14:0], 1'b0};
            end
        end
    end
    always @(negedge if1.cs_o) begin
        for (int c = 0; c < 2; c++) begin
            lat1[c] = word1[c];
            sh1[c]  = word1[c];
        end
    end
    always @(negedge if1.sclk_o) begin
        if (!if1.cs_o) begin
            for (int c = 0; c < 2; c++) begin
                if1.data_i[c] = sh1[c][15];
                sh1[c] = {sh1[c][14:0], 1'b0};
            end
        end
    end

    // The currently observed instance.
    logic        sel;
    logic        m_cs, m_sclk, m_valid, m_err, m_ovr, m_busy;
    logic [23:0] m_data;
    logic [7:0]  m_lead;
    assign m_cs    = sel ? if1.cs_o    : if0.cs_o;
    assign m_sclk  = sel ? if1.sclk_o  : if0.sclk_o;
    assign m_valid = sel ? if1.valid_o : if0.valid_o;
    assign m_err   = sel ? if1.err_o   : if0.err_o;
    assign m_data  = sel ? if1.data_o  : if0.data_o;
    assign m_lead  = sel ? if1.lead_o  : if0.lead_o;
    assign m_ovr   = sel ? ovr1        : ovr0;
    assign m_busy  = sel ? busy1       : busy0;

    int nvec  = 0;
    int nfail = 0;
    int tprev = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_words(input logic [15:0] a, input logic [15:0] b);
        if (sel) begin
            word1[0] = a;
            word1[1] = b;
        end else begin
            word0[0] = a;
            word0[1] = b;
        end
    endtask

    task automatic rand_word(output logic [15:0] w);
        w[11:0]  = 12'($urandom);
        w[15:12] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    endtask

    // Waits for one strobe and checks it against the words the ADC models latched.
    task automatic wait_valid(input string tag, input int budget, input int drop_en_at,
                              output int t_valid, output logic ovr_first);
        int          n;
        int          low;
        bit          got;
        logic [23:0] ed;
        logic [7:0]  el;
        logic [15:0] w;
        n = 0; low = 0; got = 0; t_valid = -1; ovr_first = 1'b0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (!m_cs) begin
                low++;
                if (low == 1) ovr_first = m_ovr;
                if (drop_en_at > 0 && low == drop_en_at) begin
                    if (sel) en1 = 1'b0;
                    else     en0 = 1'b0;
                end
            end
            if (m_valid) got = 1;
        end
        chk($sformatf("%s.valid_seen", tag), 64'(got), 64'd1);
        if (got) begin
            for (int c = 0; c < 2; c++) begin
                w = sel ? lat1[c] : lat0[c];
                ed[c*12 +: 12] = w[11:0] ^ SMASK;
                el[c*4 +: 4]   = w[15:12];
            end
            t_valid = cyc;
            chk($sformatf("%s.data", tag), 64'(m_data), 64'(ed));
            chk($sformatf("%s.lead", tag), 64'(m_lead), 64'(el));
            chk($sformatf("%s.err", tag), 64'(m_err), 64'(el != 8'h00));
            chk($sformatf("%s.cs_low_cycles", tag), 64'(low), 64'd128);
            chk($sformatf("%s.busy", tag), 64'(m_busy), 64'd1);
            @(negedge clk);
            chk($sformatf("%s.valid_one_cycle", tag), 64'(m_valid), 64'd0);
            chk($sformatf("%s.data_hold", tag), 64'(m_data), 64'(ed));
            chk($sformatf("%s.err_hold", tag), 64'(m_err), 64'(el != 8'h00));
        end
    endtask

    task automatic frame(input string tag, input logic [15:0] a, input logic [15:0] b);
        int   tv;
        logic of;
        set_words(a, b);
        wait_valid(tag, 3000, 0, tv, of);
        if (tprev >= 0 && tv >= 0) chk($sformatf("%s.spacing", tag), 64'(tv - tprev), 64'd2268);
        tprev = tv;
    endtask

    initial begin
        int          n;
        int          rises;
        int          nval;
        int          lowseen;
        int          tv;
        logic        of;
        logic        prev;
        logic [15:0] wa, wb;

        sel = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        if0.data_i = '0; if1.data_i = '0;
        for (int c = 0; c < 2; c++) begin
            word0[c] = 16'h0; word1[c] = 16'h0;
        end
        repeat (3) @(negedge clk);

        chk("rst.cs", 64'(m_cs), 64'd1);
        chk("rst.sclk", 64'(m_sclk), 64'd1);
        chk("rst.data", 64'(m_data), 64'd0);
        chk("rst.lead", 64'(m_lead), 64'd0);
        chk("rst.valid", 64'(m_valid), 64'd0);
        chk("rst.err", 64'(m_err), 64'd0);
        chk("rst.ovr", 64'(m_ovr), 64'd0);
        chk("rst.busy", 64'(m_busy), 64'd0);

        en0 = 1'b1; rst0 = 1'b0;
        frame("f1", 16'h0ABC, 16'h0F00);
        frame("f2_lead", 16'h0456, 16'h5123);
        chk("f2_lead.ch1_nibble", 64'(m_lead[7:4]), 64'h5);
        frame("f3_clean", 16'h0800, 16'h0FFF);
        frame("f4", 16'h0000, 16'h0800);
        frame("f5", 16'h0FFF, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            rand_word(wa);
            rand_word(wb);
            frame($sformatf("rnd%0d", k), wa, wb);
        end
        chk("dut0.no_ovr", 64'(m_ovr), 64'd0);

        // Reset at the 7th SCLK rise: partial frame is dropped, next frame is clean.
        set_words(16'h3D3C, 16'h0A5A);
        n = 0;
        while (m_cs && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid.cs_fell", 64'(m_cs), 64'd0);
        rises = 0; prev = m_sclk;
        while (rises < 7 && n < 3500) begin
            @(negedge clk);
            n++;
            if (m_sclk && !prev) rises++;
            prev = m_sclk;
        end
        chk("rstmid.rises", 64'(rises), 64'd7);
        rst0 = 1'b1;
        @(negedge clk);
        chk("rstmid.cs", 64'(m_cs), 64'd1);
        chk("rstmid.sclk", 64'(m_sclk), 64'd1);
        chk("rstmid.valid", 64'(m_valid), 64'd0);
        chk("rstmid.busy", 64'(m_busy), 64'd0);
        chk("rstmid.data", 64'(m_data), 64'd0);
        rst0 = 1'b0;
        nval = 0;
        repeat (300) begin
            @(negedge clk);
            if (m_valid) nval++;
        end
        chk("rstmid.no_partial_valid", 64'(nval), 64'd0);
        tprev = -1;
        rand_word(wa);
        rand_word(wb);
        frame("after_rst", wa, wb);

        // Drop en_i mid-frame: the frame still completes, then CS stays high.
        rand_word(wa);
        rand_word(wb);
        set_words(wa, wb);
        wait_valid("en_drop", 3000, 20, tv, of);
        lowseen = 0;
        nval = 0;
        repeat (2600) begin
            @(negedge clk);
            if (!m_cs) lowseen++;
            if (m_valid) nval++;
        end
        chk("en_drop.cs_stays_high", 64'(lowseen), 64'd0);
        chk("en_drop.no_more_valid", 64'(nval), 64'd0);
        chk("en_drop.busy", 64'(m_busy), 64'd0);

        // Fast tick instance: period shorter than a frame, every frame still correct.
        sel = 1'b1;
        rand_word(wa);
        rand_word(wb);
        set_words(wa, wb);
        en1 = 1'b1; rst1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid($sformatf("ovr%0d", k), 400, 0, tv, of);
            if (k == 0) chk("ovr0.clear_before_collision", 64'(of), 64'd0);
            chk($sformatf("ovr%0d.sticky", k), 64'(m_ovr), 64'd1);
            rand_word(wa);
            rand_word(wb);
            set_words(wa, wb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
